// File: rtl/booth_sequencer.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, N = WIDTH/2 iterations.
// Signed WIDTH x WIDTH -> 2*WIDTH product with abort and a one-cycle done pulse.
module booth_sequencer #(
    parameter int WIDTH = 16,
    localparam int N    = WIDTH / 2,
    localparam int SW   = (N > 1) ? $clog2(N) : 1,
    localparam int PW   = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    product,
    output logic [2:0]       booth_sel,
    output logic [SW-1:0]    step
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    product_r;
    logic [SW-1:0]    step_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   b_ext_s;
    logic [2:0]       window_s;
    logic [2:0]       code_s;
    logic [PW-1:0]    a_ext_s;
    logic [PW-1:0]    pp_s;
    logic [PW-1:0]    acc_next_s;
    logic             last_step_s;

    function automatic logic [2:0] booth_code(input logic [2:0] win);
        logic [2:0] code;
        case (win)
            3'b000:  code = 3'd3;
            3'b001:  code = 3'd4;
            3'b010:  code = 3'd4;
            3'b011:  code = 3'd5;
            3'b100:  code = 3'd1;
            3'b101:  code = 3'd2;
            3'b110:  code = 3'd2;
            3'b111:  code = 3'd3;
            default: code = 3'd3;
        endcase
        return code;
    endfunction

    // Multiples are formed modulo 2^PW, so negation is a plain two's-complement subtract.
    function automatic logic [PW-1:0] booth_multiple(input logic [2:0] code, input logic [PW-1:0] a_ext);
        logic [PW-1:0] m;
        case (code)
            3'd1:    m = {PW{1'b0}} - (a_ext << 1);
            3'd2:    m = {PW{1'b0}} - a_ext;
            3'd4:    m = a_ext;
            3'd5:    m = a_ext << 1;
            default: m = {PW{1'b0}};
        endcase
        return m;
    endfunction

    // Booth window selection, partial product and next accumulator value.
    always_comb begin
        b_ext_s     = {b_r, 1'b0};
        window_s    = b_ext_s[{step_r, 1'b0} +: 3];
        code_s      = booth_code(window_s);
        a_ext_s     = {{WIDTH{a_r[WIDTH-1]}}, a_r};
        pp_s        = booth_multiple(code_s, a_ext_s) << {step_r, 1'b0};
        acc_next_s  = acc_r + pp_s;
        last_step_s = (step_r == SW'(N - 1));
        if (state_r == RUN) begin
            booth_sel = code_s;
        end else begin
            booth_sel = 3'd3;
        end
    end

    // Control FSM, accumulator and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {PW{1'b0}};
            product_r <= {PW{1'b0}};
            step_r    <= {SW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        a_r     <= multiplicand;
                        b_r     <= multiplier;
                        acc_r   <= {PW{1'b0}};
                        step_r  <= {SW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        step_r  <= {SW{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (last_step_s) begin
                        acc_r     <= acc_next_s;
                        product_r <= acc_next_s;
                        step_r    <= {SW{1'b0}};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        acc_r  <= acc_next_s;
                        step_r <= step_r + SW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    step_r  <= {SW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign step    = step_r;

endmodule

// File: tb/tb_booth_sequencer.sv
// Scoreboard bench for booth_sequencer: directed corner cases plus randomized
// back-to-back multiplies checked against a plain-arithmetic reference.
module tb_booth_sequencer;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 2;
    localparam int SW    = 3;
    localparam int NRAND = 5000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  multiplicand;
    logic [WIDTH-1:0]  multiplier;
    logic              busy;
    logic              done;
    logic [2*WIDTH-1:0] product;
    logic [2:0]        booth_sel;
    logic [SW-1:0]     step;

    typedef struct {
        logic [WIDTH-1:0]   bop;
        logic [2*WIDTH-1:0] exp;
        int                 t;
    } txn_t;

    txn_t               sb[$];
    txn_t               cur;
    logic [2*WIDTH-1:0] last_prod = '0;
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 k;

    booth_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .booth_sel(booth_sel), .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*WIDTH-1:0];
    endfunction

    // Radix-4 recoded digit i of b, in -2..+2.
    function automatic int digit(input logic [WIDTH-1:0] b, input int i);
        int lo;
        lo = (i == 0) ? 0 : int'(b[2*i-1]);
        return -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h8000;
            1:       v = 16'h7FFF;
            2:       v = 16'hFFFF;
            3:       v = 16'h0000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: pops the scoreboard on done and checks per-cycle RUN/IDLE behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("latency", 64'(cyc - cur.t), 64'(N));
                    chk("product", 64'(product), 64'(cur.exp));
                    chk("busy_in_done", 64'(busy), 64'd0);
                    last_prod = cur.exp;
                end
            end else if (sb.size() != 0) begin
                k = cyc - sb[0].t;
                if (k >= N) begin
                    chk("done_missing", 64'(done), 64'd1);
                    void'(sb.pop_front());
                end else begin
                    chk("busy_run", 64'(busy), 64'd1);
                    chk("step", 64'(step), 64'(k));
                    chk("booth_sel", 64'(booth_sel), 64'(3 + digit(sb[0].bop, k)));
                    chk("product_hold_run", 64'(product), 64'(last_prod));
                end
            end else begin
                chk("busy_idle", 64'(busy), 64'd0);
                chk("booth_sel_idle", 64'(booth_sel), 64'd3);
                chk("product_hold_idle", 64'(product), 64'(last_prod));
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_step", 64'(step), 64'd0);
        chk("rst_booth_sel", 64'(booth_sel), 64'd3);
    endtask

    // Entered and left at #1 after a rising edge; start is accepted at the first edge.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit keep);
        multiplicand = av;
        multiplier   = bv;
        start        = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{bop: bv, exp: ref_mul(av, bv), t: cyc});
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        start        = keep;
        repeat (N + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        multiplicand = '0; multiplier = '0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(16'd3, 16'd5, 1'b0);
        chk("prod_3x5", 64'(product), 64'h0000000F);

        // Abort while step is 4.
        multiplicand = 16'd100; multiplier = 16'd77; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{bop: 16'd77, exp: ref_mul(16'd100, 16'd77), t: cyc});
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_step", 64'(step), 64'd0);
        chk("abort_product", 64'(product), 64'h0000000F);
        repeat (2) @(posedge clk);
        #1;

        issue(16'hFFF9, 16'd6, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0);
        chk("prod_min_sq", 64'(product), 64'h40000000);
        issue(16'h7FFF, 16'h8000, 1'b0);

        // start together with abort in IDLE is ignored.
        multiplicand = 16'd9; multiplier = 16'd9; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'd0);

        // Reset pulse while step is 3.
        multiplicand = 16'd1234; multiplier = 16'd4321; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{bop: 16'd4321, exp: ref_mul(16'd1234, 16'd4321), t: cyc});
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_step", 64'(step), 64'd3);
        reset = 1'b1;
        sb.delete();
        last_prod = '0;
        #1;
        check_reset_values();
        @(posedge clk); #1 reset = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        issue(16'd2, 16'd2, 1'b0);
        chk("prod_2x2", 64'(product), 64'h00000004);

        // Randomized operands with start held high between operations.
        for (int i = 0; i < NRAND; i++) begin
            issue(pick(), pick(), i != NRAND - 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
